// File: rtl/mmio_arbiter.sv
// Two-port round-robin MMIO arbiter owning the LED register, the synchronized
// switch inputs and a sticky unmapped-access fault flag.
module mmio_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LED_W  = 10,
  parameter int SW_W   = 10,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 16'hC000,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 16'hC001,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 16'hC002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              fault,
  output logic              state_dbg
);

  // Handshake: a requester holds reqN/weN/addrN/wdataN stable until it sees
  // the one-cycle gntN pulse, then drops or replaces the request next cycle.

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state;
  logic                win_id;
  logic                last_id;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [LED_W-1:0]    led_q;
  logic                fault_q;
  logic [SW_W-1:0]     sw_meta;
  logic [SW_W-1:0]     sw_sync;

  logic                pick1;
  logic                active;
  logic                hit_led;
  logic                hit_sw;
  logic                hit_stat;
  logic                unmapped;
  logic                led_wr;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_wdata_hi;

  assign pick1    = req1 & (~req0 | ~last_id);
  // A reset sampled in the ACCESS cycle aborts the access, so it also masks
  // the grant and the LED bypass in that same cycle.
  assign active   = (state == ACCESS) & ~rst;
  assign hit_led  = (addr_q == LED_ADDR);
  assign hit_sw   = (addr_q == SW_ADDR);
  assign hit_stat = (addr_q == STAT_ADDR);
  assign unmapped = ~(hit_led | hit_sw | hit_stat);
  assign led_wr   = active & we_q & hit_led;

  always_comb begin
    rd_val = '0;
    if (hit_led) rd_val[LED_W-1:0] = led_q;
    else if (hit_sw) rd_val[SW_W-1:0] = sw_sync;
    else if (hit_stat) rd_val[0] = fault_q;
  end

  assign gnt0      = active & ~win_id;
  assign gnt1      = active & win_id;
  assign rdata0    = gnt0 ? rd_val : '0;
  assign rdata1    = gnt1 ? rd_val : '0;
  assign led_out   = led_wr ? wdata_q[LED_W-1:0] : led_q;
  assign fault     = fault_q;
  assign state_dbg = (state == ACCESS);

  assign unused_wdata_hi = ^wdata_q[DATA_W-1:LED_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      win_id  <= 1'b0;
      last_id <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
      fault_q <= 1'b0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            win_id  <= pick1;
            we_q    <= pick1 ? we1 : we0;
            addr_q  <= pick1 ? addr1 : addr0;
            wdata_q <= pick1 ? wdata1 : wdata0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (led_wr) led_q <= wdata_q[LED_W-1:0];
          if (unmapped) fault_q <= 1'b1;
          else if (we_q & hit_stat & wdata_q[0]) fault_q <= 1'b0;
          last_id <= win_id;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter: register map, round-robin order, reset
// abort and switch synchronizer latency.
module tb_mmio_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 10;
  localparam int SW = 10;
  localparam logic [AW-1:0] LED_ADDR  = 16'hC000;
  localparam logic [AW-1:0] SW_ADDR   = 16'hC001;
  localparam logic [AW-1:0] STAT_ADDR = 16'hC002;

  logic          stim_clk = 1'b0;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic [SW-1:0] sw_in;
  logic [LW-1:0] led_out;
  logic          fault;
  logic          state_dbg;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [LW-1:0] led_seen;
  logic [1:0]    rr_exp [8];

  always #5 stim_clk = ~stim_clk;

  mmio_arbiter dut (
    .clk(stim_clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rdata1(rdata1),
    .sw_in(sw_in), .led_out(led_out), .fault(fault), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge stim_clk);
    #1;
  endtask

  // Issues one access on the given port, waits (bounded) for its grant and
  // checks latency, exclusivity and read data against the expected queue.
  task automatic do_access(input logic port, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                           output logic [LW-1:0] led_at_gnt);
    int   waited;
    logic got;
    logic [DW-1:0] exp;
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
    end
    if (!we) exp_q.push_back(exp_rd);
    waited = 0;
    got = 1'b0;
    led_at_gnt = 'x;
    while (!got && waited < 8) begin
      @(negedge stim_clk);
      if (port ? gnt1 : gnt0) got = 1'b1;
      else waited++;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      led_at_gnt = led_out;
      check("gnt_latency", 32'(waited), 32'd1);
      check("other_gnt_low", 32'(port ? gnt0 : gnt1), 32'd0);
      check("other_rdata_zero", 32'(port ? rdata0 : rdata1), 32'd0);
      if (!we) begin
        exp = exp_q.pop_front();
        check("rdata", 32'(port ? rdata1 : rdata0), 32'(exp));
      end
    end else if (!we) begin
      void'(exp_q.pop_front());
    end
    next_cycle();
    if (port) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    sw_in = '0;
    rr_exp = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    // Clock/reset
    repeat (3) @(posedge stim_clk);
    @(negedge stim_clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    next_cycle();
    rst = 1'b0;

    // LED write from port 0
    do_access(1'b0, 1'b1, LED_ADDR, 16'h0001, 16'h0000, led_seen);
    check("led_at_gnt", 32'(led_seen), 32'h001);
    @(negedge stim_clk);
    check("led_after_write", 32'(led_out), 32'h001);
    check("fault_after_led", 32'(fault), 32'd0);

    // Switch read after synchronizer settles
    sw_in = 10'h002;
    repeat (3) next_cycle();
    do_access(1'b0, 1'b0, SW_ADDR, 16'h0000, 16'h0002, led_seen);

    // Unmapped write from port 1, status read and clear
    next_cycle();
    do_access(1'b1, 1'b1, 16'h1234, 16'hBEEF, 16'h0000, led_seen);
    check("led_unmapped_gnt", 32'(led_seen), 32'h001);
    @(negedge stim_clk);
    check("fault_set", 32'(fault), 32'd1);
    check("led_unchanged", 32'(led_out), 32'h001);
    next_cycle();
    do_access(1'b1, 1'b0, STAT_ADDR, 16'h0000, 16'h0001, led_seen);
    next_cycle();
    do_access(1'b1, 1'b1, STAT_ADDR, 16'h0001, 16'h0000, led_seen);
    @(negedge stim_clk);
    check("fault_cleared", 32'(fault), 32'd0);

    // Round robin: both ports read LED continuously; last grant went to port 1
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = LED_ADDR;
    req1 = 1'b1; we1 = 1'b0; addr1 = LED_ADDR;
    for (int i = 0; i < 8; i++) begin
      @(negedge stim_clk);
      check($sformatf("rr_gnt_%0d", i), 32'({gnt0, gnt1}), 32'(rr_exp[i]));
      if (gnt0) check("rr_rdata0", 32'(rdata0), 32'h0001);
      if (gnt1) check("rr_rdata1", 32'(rdata1), 32'h0001);
    end
    next_cycle();
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset during ACCESS aborts the LED write
    next_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = LED_ADDR; wdata0 = 16'h03FF;
    next_cycle();
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge stim_clk);
    check("abort_state_access", 32'(state_dbg), 32'd1);
    check("abort_no_gnt0", 32'(gnt0), 32'd0);
    check("abort_led_not_written", 32'(led_out), 32'h001);
    next_cycle();
    rst = 1'b0;
    @(negedge stim_clk);
    check("abort_state_idle", 32'(state_dbg), 32'd0);
    check("abort_led_reset", 32'(led_out), 32'd0);
    check("abort_gnt0_after", 32'(gnt0), 32'd0);

    // Switch change one edge before the read is sampled returns the old value
    sw_in = '0;
    repeat (3) next_cycle();
    next_cycle();
    sw_in = 10'h3FF;
    do_access(1'b0, 1'b0, SW_ADDR, 16'h0000, 16'h0000, led_seen);
    next_cycle();
    next_cycle();
    do_access(1'b0, 1'b0, SW_ADDR, 16'h0000, 16'h03FF, led_seen);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
